// File: rtl/mode_select_ctrl_if.sv
// rtl/mode_select_ctrl_if.sv - mode request/acknowledge handshake between controller and datapath
// Purpose : carries the pending mode, its request strobe and the datapath acknowledge.
// Signals : mode_req_o  - controller requests a mode change (held until ack)
//           pend_mode_o - requested mode, stable while mode_req_o is high
//           mode_ack_i  - datapath accepts pend_mode_o
// Modports: master - the mode controller; slave - the mode-consuming datapath.

interface mode_select_ctrl_if;
    logic       mode_req_o;
    logic [1:0] pend_mode_o;
    logic       mode_ack_i;

    modport master (
        output mode_req_o,
        output pend_mode_o,
        input  mode_ack_i
    );

    modport slave (
        input  mode_req_o,
        input  pend_mode_o,
        output mode_ack_i
    );
endinterface

// File: rtl/mode_select_ctrl.sv
// rtl/mode_select_ctrl.sv - button-driven operating-mode sequencer with req/ack commit
// Purpose : synchronizes and debounces four push-buttons, arbitrates press events by
//           fixed priority (bit 3 highest) and requests the resulting mode from the
//           datapath; mode_o is committed only when the datapath acknowledges.
// Ports   : clk_i          - system clock, rising edge
//           rst_ni         - asynchronous active-low reset
//           buttons_i[3:0] - raw asynchronous push-buttons, active-high
//           mode_if        - master side of mode_select_ctrl_if (req / pending mode / ack)
//           mode_o[1:0]    - committed mode
//           mode_changed_o - one-cycle pulse on the cycle mode_o updates
//           busy_o         - high whenever the sequencer is not idle
//           timeout_o      - sticky ack-timeout flag
// Options : define MODE_SELECT_CTRL_TIMEOUT_EN to abort a request that sees no ack within
//           TIMEOUT_CYCLES; without it REQ waits indefinitely and timeout_o is tied low.

module mode_select_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned CNT_W           = 17,
    parameter logic [1:0]  RESET_MODE      = 2'b00,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [3:0]                 buttons_i,
    mode_select_ctrl_if.master         mode_if,
    output logic [1:0]                 mode_o,
    output logic                       mode_changed_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button conditioning
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_sync_d;     // previous synchronized value, to detect a change
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_db;
    logic [3:0]       r_db_d;

    // Sequencer
    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       r_pend;
    logic             r_changed;

    logic [3:0]       w_press;
    logic             w_any_press;
    logic [1:0]       w_win_mode;
    logic             w_load_pend;
    logic             w_commit;
    logic             w_expire;

    // Two-flop synchronizer followed by a per-button stability counter. The counter
    // restarts on any movement of the synchronized level, so only a level that holds
    // still for DEBOUNCE_CYCLES consecutive samples is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
            r_db     <= '0;
            r_db_d   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= buttons_i;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            r_db_d   <= r_db;
            for (int i = 0; i < 4; i++) begin
                if ((r_sync2[i] == r_db[i]) || (r_sync2[i] != r_sync_d[i])) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press     = r_db & ~r_db_d;
    assign w_any_press = |w_press;

    // Fixed priority: the highest-index pulsing button wins, lower ones are discarded.
    always_comb begin
        w_win_mode = 2'b11;
        if (w_press[3]) begin
            w_win_mode = 2'b00;
        end else if (w_press[2]) begin
            w_win_mode = 2'b01;
        end else if (w_press[1]) begin
            w_win_mode = 2'b10;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_pend = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_press) begin
                    if (w_win_mode != r_mode) begin
                        w_load_pend = 1'b1;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_state_nxt = ST_WAIT_REL;
                    end
                end
            end
            ST_REQ: begin
                // An ack in the same cycle as a timeout expiry still commits.
                if (mode_if.mode_ack_i) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_WAIT_REL;
                end else if (w_expire) begin
                    w_state_nxt = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                // Holding any button keeps us here, so a held button never re-triggers.
                if (r_db == 4'b0000) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_mode    <= RESET_MODE;
            r_pend    <= RESET_MODE;
            r_changed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_changed <= w_commit;
            if (w_load_pend) begin
                r_pend <= w_win_mode;
            end
            if (w_commit) begin
                r_mode <= r_pend;
            end
        end
    end

`ifdef MODE_SELECT_CTRL_TIMEOUT_EN
    localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    // The counter sits at zero outside REQ, so it is always fresh on entry to REQ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != ST_REQ) begin
                r_to_cnt <= '0;
            end else if (!w_expire) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_commit) begin
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_expire  = (r_state == ST_REQ) && (r_to_cnt == TO_LAST);
    assign timeout_o = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Request and busy decode straight from the state register, so an asynchronous
    // reset drops them in the same cycle.
    assign mode_if.mode_req_o  = (r_state == ST_REQ);
    assign mode_if.pend_mode_o = r_pend;
    assign mode_o              = r_mode;
    assign mode_changed_o      = r_changed;
    assign busy_o              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mode_select_ctrl.sv
// tb/tb_mode_select_ctrl.sv - scoreboard bench for mode_select_ctrl

module tb_mode_select_ctrl;
    localparam int DEB = 4;
    localparam int TO  = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] buttons = 4'b0000;
    logic [1:0] mode_o;
    logic       mode_changed_o;
    logic       busy_o;
    logic       timeout_o;

    mode_select_ctrl_if mif();

    mode_select_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (17),
        .RESET_MODE     (2'b00),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .buttons_i     (buttons),
        .mode_if       (mif),
        .mode_o        (mode_o),
        .mode_changed_o(mode_changed_o),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int exp_req_q[$];
    int exp_commit_q[$];
    int model_mode = 0;
    bit model_to   = 1'b0;
    bit ack_en     = 1'b1;
    int ack_dly    = 0;

    bit prev_req = 1'b0;
    bit prev_chg = 1'b0;
    int pend_cap = 0;
    int ack_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rule: highest set button wins; button i maps to mode 3-i.
    function automatic int win_mode(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) return 3 - i;
        end
        return -1;
    endfunction

    task automatic hold(input logic [3:0] v, input int n);
        buttons = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", busy_o, 0);
    endtask

    // One press episode from all-released to all-released. v1 rises first; v2 adds
    // buttons later while v1 is still held, and must never produce a request.
    task automatic episode(input logic [3:0] v1, input int l1, input logic [3:0] v2,
                           input int l2, input bit ack_on, input int dly);
        int m;
        ack_en  = ack_on;
        ack_dly = dly;
        m = win_mode(v1);
        if (m != model_mode) begin
            exp_req_q.push_back(m);
            if (ack_on) begin
                exp_commit_q.push_back(m);
                model_mode = m;
                model_to   = 1'b0;
            end else begin
                model_to = 1'b1;
            end
        end
        hold(v1, l1);
        if (v2 != 4'b0000) hold(v1 | v2, l2);
        hold(4'b0000, DEB + 6);
        wait_idle();
        check("mode_after", mode_o, model_mode);
        check("req_low_idle", mif.mode_req_o, 0);
        check("timeout_flag", timeout_o, model_to);
        ack_en = 1'b1;
    endtask

    task automatic glitch(input logic [3:0] mask, input int steps);
        logic [3:0] g;
        for (int k = 0; k < steps; k++) begin
            g = 4'($urandom_range(1, 15)) & mask;
            if (g == 4'b0000) g = mask;
            hold(g, $urandom_range(1, 3));
            check("glitch_busy", busy_o, 0);
            hold(4'b0000, $urandom_range(1, 3));
            check("glitch_busy", busy_o, 0);
        end
        hold(4'b0000, DEB + 6);
        check("glitch_busy", busy_o, 0);
    endtask

    // Datapath responder: acknowledges ack_dly cycles after the request is seen.
    initial begin
        mif.mode_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            mif.mode_ack_i = 1'b0;
            if (rst_n && mif.mode_req_o && ack_en) begin
                if (ack_cnt >= ack_dly) begin
                    mif.mode_ack_i = 1'b1;
                    ack_cnt = 0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT raises a request or a commit pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                prev_chg = 1'b0;
            end else begin
                if (mif.mode_req_o && !prev_req) begin
                    if (exp_req_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req actual=pend %0d required=no request (t=%0t)",
                                 mif.pend_mode_o, $time);
                    end else begin
                        check("req_pend", mif.pend_mode_o, exp_req_q.pop_front());
                    end
                    pend_cap = mif.pend_mode_o;
                end else if (mif.mode_req_o && prev_req) begin
                    check("pend_stable", mif.pend_mode_o, pend_cap);
                end
                if (mode_changed_o) begin
                    check("chg_single", prev_chg, 0);
                    if (exp_commit_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_commit actual=mode %0d required=no commit (t=%0t)",
                                 mode_o, $time);
                    end else begin
                        check("commit_mode", mode_o, exp_commit_q.pop_front());
                    end
                end
                prev_req = mif.mode_req_o;
                prev_chg = mode_changed_o;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m;
        int n;
        logic [3:0] v1;
        logic [3:0] v2;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mode", mode_o, 0);
        check("rst_pend", mif.pend_mode_o, 0);
        check("rst_req", mif.mode_req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_changed", mode_changed_o, 0);
        check("rst_timeout", timeout_o, 0);

        episode(4'b0010, 10, 4'b0000, 0, 1'b1, 3);
        episode(4'b1001, 10, 4'b0000, 0, 1'b1, 1);
        glitch(4'b0100, 8);
        episode(4'b0010, 12, 4'b0001, 6, 1'b1, 2);
        episode(4'b0001, 10, 4'b0000, 0, 1'b1, 0);

        // Reset in the middle of a handshake.
        ack_en = 1'b0;
        v1 = 4'b0100;
        m  = win_mode(v1);
        if (m != model_mode) exp_req_q.push_back(m);
        buttons = v1;
        n = 0;
        while (!mif.mode_req_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_req_seen", mif.mode_req_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req", mif.mode_req_o, 0);
        check("midrst_mode", mode_o, 0);
        check("midrst_busy", busy_o, 0);
        buttons = 4'b0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_mode = 0;
        model_to   = 1'b0;
        ack_en     = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_mode", mode_o, 0);

        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 1) == 1) glitch(4'($urandom_range(1, 15)), $urandom_range(2, 5));
            v1 = 4'($urandom_range(1, 15));
            v2 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            episode(v1, $urandom_range(8, 14), v2, $urandom_range(3, 8), 1'b1, $urandom_range(0, 4));
        end

`ifdef MODE_SELECT_CTRL_TIMEOUT_EN
        v1 = (model_mode == 0) ? 4'b0100 : 4'b1000;
        episode(v1, 10, 4'b0000, 0, 1'b0, 0);
        v1 = (model_mode == 3) ? 4'b0010 : 4'b0001;
        episode(v1, 10, 4'b0000, 0, 1'b1, 2);
`endif

        check("req_q_empty", exp_req_q.size(), 0);
        check("commit_q_empty", exp_commit_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
